// File: rtl/dtr_responder.sv
// Behavioural stand-in for the on-die digital temperature readout primitive.
// It answers the controller's start-pulse/readout handshake. A start pulse is
// qualified by its minimum width. A timed conversion follows, and the result
// is then presented as {done, 1'b0, code[5:0]}. In ramp mode the reported code
// comes from an internal counter. That gives the controller a changing value
// without any external stimulus.

module dtr_responder #(
    parameter int SYSTEM_FREQUENCY = 15000000,
    parameter int CONVERSION_US    = 10,
    parameter int MIN_PULSE_CYCLES = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rstn,
    input  logic       i_StartPulse,
    input  logic [5:0] i_TempCode,
    input  logic       i_RampEnable,
    output logic [7:0] o_DtrOut,
    output logic       o_Busy,
    output logic       o_Error
);

    // Number of clocks spent in CONVERT; the integer division mirrors how the
    // controller derives its own timeout, so both sides agree on the figure.
    localparam int CONV_CYCLES = SYSTEM_FREQUENCY / 1000000 * CONVERSION_US;
    localparam int CONV_W      = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int PULSE_W     = $clog2(MIN_PULSE_CYCLES + 1);

    localparam logic [CONV_W-1:0]  CONV_LAST    = CONV_W'(CONV_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_ACCEPT = PULSE_W'(MIN_PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         rst_pipe;
    logic               rst_n;
    logic               start_meta;
    logic               start_sync;
    logic               start_prev;
    logic               start_rise;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [CONV_W-1:0]  conv_cnt;
    logic [5:0]         ramp;
    logic [5:0]         snapshot;
    logic               snap_from_ramp;

    // Reset asserts asynchronously but releases two clocks after the pin, so
    // every flop below leaves reset on the same clean edge.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    // Two-flop synchronizer for the asynchronous start pin, plus one more
    // stage holding the previous synced level for edge detection.
    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            start_meta <= i_StartPulse;
            start_sync <= start_meta;
            start_prev <= start_sync;
        end
    end

    assign start_rise = start_sync & ~start_prev;

    // Handshake state machine. All outputs are registered here, and so are the
    // pulse and conversion counters, the code snapshot and the ramp counter.
    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            o_DtrOut       <= 8'h00;
            o_Busy         <= 1'b0;
            o_Error        <= 1'b0;
            pulse_cnt      <= '0;
            conv_cnt       <= '0;
            ramp           <= 6'd0;
            snapshot       <= 6'd0;
            snap_from_ramp <= 1'b0;
        end else begin
            case (state)
                // DONE keeps the last result on the bus until a new start
                // arrives. Only the done bit drops then; the code bits stay.
                IDLE, DONE: begin
                    if (start_rise) begin
                        state       <= ARM;
                        o_DtrOut[7] <= 1'b0;
                        o_Busy      <= 1'b1;
                        pulse_cnt   <= PULSE_W'(1);
                    end
                end

                // The pulse must stay high long enough to count as a start.
                // A pulse that is too short is a protocol error, not a request.
                ARM: begin
                    if (start_sync) begin
                        pulse_cnt <= pulse_cnt + PULSE_W'(1);
                        if (pulse_cnt >= PULSE_ACCEPT) begin
                            state          <= CONVERT;
                            conv_cnt       <= '0;
                            snapshot       <= i_RampEnable ? ramp : i_TempCode;
                            snap_from_ramp <= i_RampEnable;
                        end
                    end else begin
                        state   <= IDLE;
                        o_Busy  <= 1'b0;
                        o_Error <= 1'b1;
                    end
                end

                // A new start during a conversion is flagged but ignored.
                // The running conversion always finishes on schedule.
                CONVERT: begin
                    if (start_rise) begin
                        o_Error <= 1'b1;
                    end
                    if (conv_cnt == CONV_LAST) begin
                        state    <= DONE;
                        o_Busy   <= 1'b0;
                        o_DtrOut <= {1'b1, 1'b0, snapshot};
                        if (snap_from_ramp) begin
                            ramp <= ramp + 6'd1;
                        end
                    end else begin
                        conv_cnt <= conv_cnt + CONV_W'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtr_responder.sv
// Directed bench for dtr_responder at default parameters (150-clock conversion).
// A table of single-conversion vectors is followed by hand sequences. These
// cover exact latency, ramp wrap, a second rise during CONVERT, reset
// mid-conversion and a long held start.

module tb_dtr_responder;

    logic       i_Clk;
    logic       i_Rstn;
    logic       i_StartPulse;
    logic [5:0] i_TempCode;
    logic       i_RampEnable;
    logic [7:0] o_DtrOut;
    logic       o_Busy;
    logic       o_Error;

    int tests_run;
    int tests_failed;

    dtr_responder dut (
        .i_Clk        (i_Clk),
        .i_Rstn       (i_Rstn),
        .i_StartPulse (i_StartPulse),
        .i_TempCode   (i_TempCode),
        .i_RampEnable (i_RampEnable),
        .o_DtrOut     (o_DtrOut),
        .o_Busy       (o_Busy),
        .o_Error      (o_Error)
    );

    // 100 MHz simulation clock; only cycle counts matter to the design.
    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [5:0] temp;
        logic       ramp;
        int         pulse_len;
        logic       exp_busy;
        logic [7:0] exp_dtr;
        logic       exp_err;
    } vec_t;

    vec_t vecs [9];

    // Advance n rising edges, then settle 1 ns so that outputs are sampled
    // away from the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        i_StartPulse = 1'b0;
        i_Rstn       = 1'b0;
        #1;
        tick(2);
        i_Rstn = 1'b1;
        tick(4);
    endtask

    // Drives a start pulse that stays high across pulse_len rising edges and
    // runs for a total of `edges` edges. It samples o_Busy after edge `probe`.
    task automatic applyStimulus(input logic [5:0] temp, input logic ramp, input int pulse_len,
                                 input int edges, input int probe, output logic probe_busy);
        i_TempCode   = temp;
        i_RampEnable = ramp;
        probe_busy   = 1'b0;
        if (pulse_len > 0) i_StartPulse = 1'b1;
        for (int k = 1; k <= edges; k++) begin
            tick(1);
            if (k == pulse_len) i_StartPulse = 1'b0;
            if (k == probe) probe_busy = o_Busy;
        end
    endtask

    initial begin
        logic busy_probe;
        int   late_busy;
        int   done_count;
        int   busy_rises;
        logic prev_done;
        logic prev_busy;

        tests_run    = 0;
        tests_failed = 0;
        i_TempCode   = 6'h00;
        i_RampEnable = 1'b0;
        i_StartPulse = 1'b0;
        i_Rstn       = 1'b1;

        // temp, ramp, pulse length, busy after edge 3, final dtr, final error
        vecs[0] = '{6'h2A, 1'b0, 10, 1'b1, 8'hAA, 1'b0};
        vecs[1] = '{6'h15, 1'b0,  4, 1'b1, 8'h95, 1'b0};
        vecs[2] = '{6'h3F, 1'b0, 10, 1'b1, 8'hBF, 1'b0};
        vecs[3] = '{6'h00, 1'b0,  6, 1'b1, 8'h80, 1'b0};
        vecs[4] = '{6'h2A, 1'b0,  3, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{6'h2A, 1'b0,  2, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{6'h2A, 1'b0,  1, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{6'h2A, 1'b1, 10, 1'b1, 8'h80, 1'b0};
        vecs[8] = '{6'h2A, 1'b0,  0, 1'b0, 8'h00, 1'b0};

        // Reset values while reset is held
        i_Rstn = 1'b0;
        #1;
        checkOutput("reset dtr", {24'd0, o_DtrOut}, 32'h00);
        checkOutput("reset busy", {31'd0, o_Busy}, 32'h0);
        checkOutput("reset error", {31'd0, o_Error}, 32'h0);
        doReset();

        for (int i = 0; i < 9; i++) begin
            doReset();
            applyStimulus(vecs[i].temp, vecs[i].ramp, vecs[i].pulse_len, 200, 3, busy_probe);
            checkOutput($sformatf("vec%0d busy@3", i), {31'd0, busy_probe}, {31'd0, vecs[i].exp_busy});
            checkOutput($sformatf("vec%0d dtr", i), {24'd0, o_DtrOut}, {24'd0, vecs[i].exp_dtr});
            checkOutput($sformatf("vec%0d busy end", i), {31'd0, o_Busy}, 32'h0);
            checkOutput($sformatf("vec%0d error", i), {31'd0, o_Error}, {31'd0, vecs[i].exp_err});
        end

        // Exact latency: the synced rise is acted on at edge 3, then 3 ARM and
        // 150 CONVERT clocks, so done is registered at edge 156.
        doReset();
        i_TempCode   = 6'h2A;
        i_RampEnable = 1'b0;
        i_StartPulse = 1'b1;
        for (int k = 1; k <= 160; k++) begin
            tick(1);
            if (k == 10) i_StartPulse = 1'b0;
            if (k == 2) checkOutput("latency busy@2", {31'd0, o_Busy}, 32'h0);
            if (k == 155) begin
                checkOutput("latency done@155", {31'd0, o_DtrOut[7]}, 32'h0);
                checkOutput("latency busy@155", {31'd0, o_Busy}, 32'h1);
            end
            if (k == 156) begin
                checkOutput("latency dtr@156", {24'd0, o_DtrOut}, 32'hAA);
                checkOutput("latency busy@156", {31'd0, o_Busy}, 32'h0);
            end
        end
        checkOutput("latency error", {31'd0, o_Error}, 32'h0);

        // Ramp mode: codes count up per conversion and wrap after 64
        doReset();
        for (int i = 0; i < 65; i++) begin
            applyStimulus(6'h15, 1'b1, 6, 170, 0, busy_probe);
            if (i < 5) checkOutput($sformatf("ramp conv%0d", i), {24'd0, o_DtrOut}, 32'h80 + i);
            if (i == 63) checkOutput("ramp conv63", {24'd0, o_DtrOut}, 32'hBF);
            if (i == 64) checkOutput("ramp wrap", {24'd0, o_DtrOut}, 32'h80);
        end
        checkOutput("ramp error", {31'd0, o_Error}, 32'h0);

        // A second rise, detected at edge 58 (52 clocks into CONVERT), is
        // flagged. The first result still lands at edge 156, and no further
        // conversion starts.
        doReset();
        i_TempCode   = 6'h11;
        i_RampEnable = 1'b0;
        i_StartPulse = 1'b1;
        late_busy    = 0;
        for (int k = 1; k <= 356; k++) begin
            tick(1);
            if (k == 10) i_StartPulse = 1'b0;
            if (k == 55) i_StartPulse = 1'b1;
            if (k == 65) i_StartPulse = 1'b0;
            if (k == 155) checkOutput("rerise done@155", {31'd0, o_DtrOut[7]}, 32'h0);
            if (k == 156) checkOutput("rerise dtr@156", {24'd0, o_DtrOut}, 32'h91);
            if (k > 156 && o_Busy) late_busy++;
        end
        checkOutput("rerise error", {31'd0, o_Error}, 32'h1);
        checkOutput("rerise no second conv", late_busy, 32'd0);
        checkOutput("rerise dtr held", {24'd0, o_DtrOut}, 32'h91);

        // Reset mid-conversion clears everything, including the ramp counter
        doReset();
        applyStimulus(6'h00, 1'b1, 6, 170, 0, busy_probe);
        checkOutput("rstmid first", {24'd0, o_DtrOut}, 32'h80);
        i_StartPulse = 1'b1;
        for (int k = 1; k <= 81; k++) begin
            tick(1);
            if (k == 6) i_StartPulse = 1'b0;
        end
        checkOutput("rstmid busy before", {31'd0, o_Busy}, 32'h1);
        i_Rstn = 1'b0;
        #1;
        checkOutput("rstmid dtr", {24'd0, o_DtrOut}, 32'h00);
        checkOutput("rstmid busy", {31'd0, o_Busy}, 32'h0);
        tick(2);
        i_Rstn = 1'b1;
        tick(4);
        applyStimulus(6'h00, 1'b1, 6, 170, 0, busy_probe);
        checkOutput("rstmid restart dtr", {24'd0, o_DtrOut}, 32'h80);
        checkOutput("rstmid restart error", {31'd0, o_Error}, 32'h0);

        // A start held for 1000 clocks gives one conversion. The code is taken
        // at the snapshot, so a later i_TempCode change is ignored.
        doReset();
        i_TempCode   = 6'h05;
        i_RampEnable = 1'b0;
        i_StartPulse = 1'b1;
        done_count   = 0;
        busy_rises   = 0;
        prev_done    = o_DtrOut[7];
        prev_busy    = o_Busy;
        for (int k = 1; k <= 1200; k++) begin
            tick(1);
            if (k == 80) i_TempCode = 6'h3A;
            if (k == 1000) i_StartPulse = 1'b0;
            if (o_DtrOut[7] && !prev_done) done_count++;
            if (o_Busy && !prev_busy) busy_rises++;
            prev_done = o_DtrOut[7];
            prev_busy = o_Busy;
        end
        checkOutput("held done count", done_count, 32'd1);
        checkOutput("held busy count", busy_rises, 32'd1);
        checkOutput("held dtr", {24'd0, o_DtrOut}, 32'h85);
        checkOutput("held error", {31'd0, o_Error}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dtr_responder.md
Name: dtr_responder

Overview:
- Synthesizable behavioural model of the on-die DTR (digital temperature readout) primitive.
- It is the responder side of the start-pulse/readout interface driven by our FPGA temperature measurement controller.
- It accepts a start pulse, performs a timed "conversion", then presents an 8-bit readout word with a done flag.
- It replaces the hard primitive in simulation and in non-Lattice builds, so the controller can be exercised end to end.

Parameters:
- SYSTEM_FREQUENCY, 15000000, i_Clk frequency in Hz.
- CONVERSION_US, 10, conversion time in microseconds. CONV_CYCLES = SYSTEM_FREQUENCY/1000000*CONVERSION_US, must be >= 1.
- MIN_PULSE_CYCLES, 4, minimum synchronized high time of i_StartPulse, in clocks, for a start to be accepted.

Ports:
- i_Clk  input  1  system clock
- i_Rstn  input  1  asynchronous active-low reset
- i_StartPulse  input  1  start request from the controller; asynchronous, synchronized internally
- i_TempCode  input  6  temperature code to report when ramp mode is off
- i_RampEnable  input  1  1 = report internal ramp counter instead of i_TempCode
- o_DtrOut  output  8  bit7 = done, bit6 = 0, bits5:0 = temperature code
- o_Busy  output  1  high while in ARM or CONVERT
- o_Error  output  1  sticky protocol error flag, cleared only by reset

Behaviour:
- Reset is asynchronous: assert on i_Rstn low, release synchronously.
- Reset values:
  - o_DtrOut = 8'h00, o_Busy = 0, o_Error = 0.
  - State = IDLE, ramp counter = 0, synchronizer flops = 0.
- i_StartPulse passes through a 2-flop synchronizer. A rising edge is detected when the synced level is 1 and its previous value was 0, i.e. 3 clocks after the pin rises.
- States are IDLE, ARM, CONVERT, DONE.
- IDLE: on a rising edge, go to ARM, clear o_DtrOut[7] (code bits held) and load the pulse counter with 1.
- ARM:
  - While synced start stays high, increment the pulse counter.
  - When the counter reaches MIN_PULSE_CYCLES, go to CONVERT. In the same clock, snapshot the code: i_RampEnable ? ramp : i_TempCode.
  - If synced start falls before the counter reaches MIN_PULSE_CYCLES, set o_Error and return to IDLE. o_DtrOut is unchanged (done stays 0).
- CONVERT:
  - Count CONV_CYCLES clocks. On the last one, set o_DtrOut = {1'b1, 1'b0, snapshot} and go to DONE.
  - If ramp mode was used for this snapshot, increment ramp at the same time (63 wraps to 0).
  - Any rising edge during CONVERT is ignored and sets o_Error. The conversion continues unaffected.
  - The start level falling during CONVERT is legal.
- DONE: o_DtrOut is held stable. A rising edge behaves as in IDLE.
- o_Busy = 1 exactly in ARM and CONVERT.
- Latency, from the first clock with the synced start high to done: MIN_PULSE_CYCLES - 1 clocks in ARM, plus CONV_CYCLES clocks in CONVERT. Done becomes visible at the register output on the following edge.
- Changes to i_TempCode or i_RampEnable after the snapshot do not affect the current result.
- Reset mid-conversion: immediate return to IDLE with all outputs at reset values. Ramp returns to 0 and no done pulse is produced.
- A start held high continuously produces exactly one conversion. A new conversion needs a low and then a high again.

Test Plan:
- Defaults (CONV_CYCLES = 150), i_TempCode = 6'h2A, 10-clock start pulse -> o_Busy high, then o_DtrOut = 8'hAA. Done appears MIN_PULSE_CYCLES - 1 + 150 clocks after the synced rise. o_Error = 0.
- 2-clock start pulse -> state returns to IDLE, o_Error = 1, o_DtrOut[7] = 0, no conversion.
- i_RampEnable = 1, five back-to-back valid starts -> codes 0, 1, 2, 3, 4 (o_DtrOut = 8'h80..8'h84). After 64 conversions the code wraps to 0.
- Second rising edge 50 clocks into CONVERT -> first result still delivered at the nominal time, o_Error = 1, no second conversion.
- i_Rstn pulled low 75 clocks into CONVERT -> o_DtrOut = 0 and o_Busy = 0 immediately (asynchronous). After release, a new valid start completes normally.
- Start held high for 1000 clocks -> exactly one done assertion. i_TempCode changed mid-CONVERT does not alter the reported code.
